// File: rtl/ula_pkg.sv
// Shared constants for the sequential ULA: opcodes, FSM state encoding and
// bit positions of the condition flags inside the packed flag register.
package ula_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/ula_mul.sv
// WIDTH-step shift-add multiplier. product shows the accumulator including the
// step being taken this cycle, so it is final whenever last is high.
module ula_mul
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               run;

    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign product  = acc_next;
    assign last     = run && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ula_seq.sv
// Registered ALU with condition flags and a start/busy/done handshake; MUL is
// delegated to the multi-cycle shift-add unit, everything else settles in one edge.
module ula_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       tula,
    input  logic [WIDTH-1:0] barramento,
    input  logic [WIDTH-1:0] acumulador,
    output logic [WIDTH-1:0] ulaout,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v,
    output logic             busy,
    output logic             done
);

    state_t             state;
    logic [3:0]         flags;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic               res_v;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   prod_lo;
    logic               mul_last;
    logic               mul_load;

    assign sum      = {1'b0, acumulador} + {1'b0, barramento};
    assign diff     = {1'b0, acumulador} - {1'b0, barramento};
    assign prod_lo  = product[WIDTH-1:0];
    assign mul_load = (state == ST_IDLE) && start && (tula == OP_MUL);

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (tula)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (acumulador[WIDTH-1] == barramento[WIDTH-1]) &&
                        (sum[WIDTH-1] != acumulador[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (acumulador[WIDTH-1] != barramento[WIDTH-1]) &&
                        (diff[WIDTH-1] != acumulador[WIDTH-1]);
            end
            OP_AND: res = acumulador & barramento;
            OP_OR:  res = acumulador | barramento;
            OP_XOR: res = acumulador ^ barramento;
            OP_NOT: res = ~acumulador;
            OP_SHL: begin
                res   = {acumulador[WIDTH-2:0], 1'b0};
                res_c = acumulador[WIDTH-1];
            end
            OP_SHR: begin
                res   = {1'b0, acumulador[WIDTH-1:1]};
                res_c = acumulador[0];
            end
            default: ;
        endcase
    end

    ula_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mul_load),
        .a       (acumulador),
        .b       (barramento),
        .product (product),
        .last    (mul_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ulaout <= '0;
            flags  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (tula == OP_MUL) begin
                            state <= ST_MUL;
                            busy  <= 1'b1;
                        end else begin
                            // Opcodes above SHR (other than MUL) are NOPs: hold result and flags.
                            if (tula <= OP_SHR) begin
                                ulaout         <= res;
                                flags[FLAG_Z]  <= (res == '0);
                                flags[FLAG_C]  <= res_c;
                                flags[FLAG_N]  <= res[WIDTH-1];
                                flags[FLAG_V]  <= res_v;
                            end
                            done <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        ulaout         <= prod_lo;
                        flags[FLAG_Z]  <= (prod_lo == '0);
                        flags[FLAG_C]  <= |product[2*WIDTH-1:WIDTH];
                        flags[FLAG_N]  <= prod_lo[WIDTH-1];
                        flags[FLAG_V]  <= 1'b0;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign flag_z = flags[FLAG_Z];
    assign flag_c = flags[FLAG_C];
    assign flag_n = flags[FLAG_N];
    assign flag_v = flags[FLAG_V];

endmodule

// File: doc/ula_seq.md
# ula_seq

Registered, parametrised arithmetic/logic unit that succeeds the combinational ULA in the datapath. It sits between the accumulator register and the internal bus, and adds logic and shift operations, condition flags, and a multi-cycle shift-add multiply. A start/busy/done handshake lets the control unit sequence it. ADD/SUB semantics are unchanged, so at WIDTH=5 the ULA's add/sub results are reproduced bit-exactly.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- tula  in  4  opcode, captured with start
- barramento  in  WIDTH  bus operand B, captured with start
- acumulador  in  WIDTH  accumulator operand A, captured with start
- ulaout  out  WIDTH  registered result
- flag_z / flag_c / flag_n / flag_v  out  1 each  zero / carry-borrow / negative (result MSB) / signed overflow, registered with ulaout
- busy  out  1  multiply in progress
- done  out  1  one-cycle pulse: ulaout and flags were just updated

## Operation
- Opcodes:
  - 0 ADD A+B
  - 1 SUB A−B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL A by 1
  - 7 SHR A by 1, logical
  - 8 MUL A×B, low WIDTH bits
  - 9–15 NOP
- Arithmetic is modulo 2^WIDTH.
- flag_c:
  - ADD: carry-out.
  - SUB: borrow (1 when A<B unsigned).
  - SHL: bit shifted out (A[MSB]).
  - SHR: A[0].
  - MUL: 1 when the high half of the 2·WIDTH product is nonzero.
  - Logic ops: 0.
- flag_v: two's-complement overflow for ADD/SUB; 0 for all other ops.
- flag_z = (ulaout==0); flag_n = ulaout[WIDTH-1]. Both are updated on every non-NOP op.
- NOP: ulaout and all flags hold; done still pulses.
- States: IDLE, MUL.
  - IDLE, start=1, tula≠8: result and flags are written at that same edge; done=1 for the next cycle; stay in IDLE.
  - IDLE, start=1, tula=8: the multiplier loads and the state moves to MUL with a counter at 0.
  - MUL: one shift-add step per cycle. After WIDTH steps, ulaout and flags are written, done=1, and the state returns to IDLE.
- start while in MUL is ignored and is not queued.
- start may be asserted in the cycle done is high; it is accepted (back-to-back).
- Operands and opcode are captured at acceptance. Input changes during MUL have no effect.

## Timing
- Reset values: ulaout=0, all flags=0, busy=0, done=0, state=IDLE, counter=0.
- Single-cycle ops: start sampled at edge k → ulaout/flags valid and done=1 during cycle k+1.
- MUL: start at edge k → busy=1 for cycles k+1 … k+WIDTH → done=1 and busy=0 in cycle k+WIDTH+1.
- busy and done are never high together.
- Reset asserted mid-MUL aborts immediately: busy=0, no done, ulaout/flags return to 0.
- Outputs change only at clock edges or asynchronously on reset; there is no combinational path from inputs to outputs.

## Structure
- Package ula_pkg holds:
  - the opcode localparams (OP_ADD … OP_MUL);
  - the state encoding (ST_IDLE, ST_MUL);
  - a flag-index constant set.
- Sub-module ula_mul implements the WIDTH-step shift-add multiplier:
  - inputs: clk, rst_n, load, A, B;
  - outputs: 2·WIDTH product, last-step indicator.
- The top level holds the FSM, the single-cycle datapath, and the flag logic.

## Test plan
- WIDTH=8, ADD A=200 B=100 → ulaout=44, c=1, v=0, n=0, z=0; done exactly 1 cycle after start.
- WIDTH=8:
  - SUB A=3 B=5 → ulaout=0xFE, c=1, n=1, v=0.
  - SUB A=0x80 B=0x01 → ulaout=0x7F, v=1, c=0.
- WIDTH=8, MUL A=13 B=11 → busy 8 cycles, done at cycle 9, ulaout=143, c=0. Also check:
  - start with ADD during busy is ignored.
  - MUL 16×16 → ulaout=0, z=1, c=1.
- WIDTH=8, SHL A=0x81 → ulaout=0x02, c=1. Then NOP (tula=12) → ulaout/flags hold, done pulses.
- WIDTH=8, rst_n low at MUL cycle 4 → busy=0 immediately, no done, ulaout=0. Then ADD 1+1 → 2 after release.
- WIDTH=5, ADD 31+1 → ulaout=0, z=1, c=1; back-to-back ADD/SUB accepted on consecutive done cycles.
